bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 16, number of requesters; fixed at 16 in this revision.
REQ-002 Parameter: TIMEOUT, 64, max GRANT cycles before forced release; used only when ARB_TIMEOUT_EN is defined.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: resetn  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  16  request lines; bit i high = requester i wants the shared bus.
REQ-006 Port: done  input  1  current owner releases bus; sampled only in GRANT.
REQ-007 Port: gnt  output  16  registered one-hot grant; all-zero when no owner.
REQ-008 Port: gnt_id  output  4  binary index of the owner; valid only while busy=1.
REQ-009 Port: busy  output  1  high while in GRANT.
REQ-010 Port: timeout_err  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-011 FSM states: IDLE, GRANT; no other states reachable.
REQ-012 IDLE with req==0: stay in IDLE; gnt=0, busy=0.
REQ-013 IDLE with req!=0 at edge N: at edge N+1 enter GRANT with gnt=onehot(winner), gnt_id=winner, busy=1; latency exactly 1 cycle.
REQ-014 Winner: the first set req bit scanning upward from (last_id+1) mod 16, wrapping 15->0.
REQ-015 last_id is updated to gnt_id on every release; an idle period does not change it.
REQ-016 GRANT: gnt, gnt_id held stable; changes to other req bits are ignored.
REQ-017 GRANT release: done=1 or req[gnt_id]=0 at edge N -> IDLE at N+1 with gnt=0, busy=0.
REQ-018 Release to new grant: exactly one IDLE cycle between consecutive owners, including back-to-back requests by the same requester.
REQ-019 Single requester: the same requester is re-granted after each one-cycle IDLE gap; no starvation.
REQ-020 gnt is always zero or one-hot; gnt and busy always agree (busy = |gnt).

Reset
REQ-021 resetn low: immediately state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, last_id=15, and the timeout counter is cleared.
REQ-022 Reset asserted during GRANT drops the grant asynchronously, with no release cycle; the first grant after reset starts its scan at requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: a counter clears on GRANT entry and increments each GRANT cycle. When it reaches TIMEOUT-1 without a release, the next edge forces IDLE, pulses timeout_err for 1 cycle and updates last_id; done on that same edge releases normally, without timeout_err.
REQ-024 ARB_TIMEOUT_EN undefined: no counter is built, a grant is held indefinitely until done or req drop, and timeout_err is tied to 0.

Structure
REQ-025 Shared package arb_pkg holds: state enum (IDLE, GRANT), NUM_REQ=16, ID_W=4 and the TIMEOUT default.
REQ-026 One sub-module, rr_pick: combinational round-robin priority picker, inputs req[15:0] and last_id[3:0], outputs any and win_id[3:0]. The one-hot gnt is produced by decoding win_id.

Verification
REQ-027 Reset then req=16'h0001 -> gnt=16'h0001, gnt_id=0, busy=1 one cycle after req is first sampled.
REQ-028 req=16'hFFFF held, done pulsed each grant -> grant order 0,1,2,...,15,0, with one IDLE cycle between grants.
REQ-029 Owner id 5, req=16'h0021, done -> IDLE one cycle, then gnt_id=0 (wrap from 5 to 0 after higher bits are clear).
REQ-030 During GRANT to id 3, req[3] drops with done=0 -> next cycle gnt=0, busy=0.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT=4, owner never asserts done -> release after 4 GRANT cycles, with timeout_err high for exactly 1 cycle; without the macro, the grant is still held after 1000 cycles.
REQ-032 resetn pulsed low mid-GRANT -> gnt=0 immediately, without waiting for a clock edge; next grant with req=16'h8001 goes to id 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   state_t        : arbiter FSM states (IDLE, GRANT)
//   NUM_REQ        : number of requesters
//   ID_W           : width of a requester index
//   TIMEOUT_DEFAULT: default forced-release limit in GRANT cycles
//   id_to_onehot   : requester index -> one-hot grant vector
package arb_pkg;

    localparam int unsigned NUM_REQ         = 16;
    localparam int unsigned ID_W            = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit scanning
// upward from last_id+1, wrapping from the top index back to 0.
//   req    : request lines
//   last_id: index of the most recent owner
//   any    : at least one request is set
//   win_id : index of the winning requester (0 when any=0)
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               any,
    output logic [ID_W-1:0]    win_id
);

    logic [ID_W-1:0] idx;

    // Offsets 1..NUM_REQ; ID_W-bit addition wraps naturally, offset NUM_REQ is last_id itself.
    always_comb begin
        any    = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = last_id + ID_W'(i + 1);
            if (!any && req[idx]) begin
                any    = 1'b1;
                win_id = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle IDLE gap between owners.
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
//   clock      : rising-edge clock
//   resetn     : asynchronous active-low reset
//   req        : request lines, one per requester
//   done       : owner releases the bus (sampled only in GRANT)
//   gnt        : registered one-hot grant, zero when no owner
//   gnt_id     : binary index of the owner, valid while busy=1
//   busy       : high while a grant is held
//   timeout_err: one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
module bus_arbiter #(
    parameter int unsigned NUM_REQ = arb_pkg::NUM_REQ,
    parameter int unsigned TIMEOUT = arb_pkg::TIMEOUT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     done,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [arb_pkg::ID_W-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout_err
);

    import arb_pkg::*;

    state_t            state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [ID_W-1:0]   gnt_id_n;
    logic              busy_n;
    logic [ID_W-1:0]   last_id, last_id_n;
    logic              pick_any;
    logic [ID_W-1:0]   pick_id;
    logic              free;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;
    logic             expired;

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    rr_pick u_pick (
        .req     (req),
        .last_id (last_id),
        .any     (pick_any),
        .win_id  (pick_id)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        last_id_n = last_id;
        free      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt;
        err_n     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n  = GRANT;
                    gnt_n    = id_to_onehot(pick_id);
                    gnt_id_n = pick_id;
                    busy_n   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_n    = '0;
`endif
                end
            end
            GRANT: begin
                free = done || !req[gnt_id];
`ifdef ARB_TIMEOUT_EN
                // A normal release on the expiry edge wins over the timeout.
                if (!free && expired) begin
                    free  = 1'b1;
                    err_n = 1'b1;
                end
                cnt_n = cnt + CNT_W'(1);
`endif
                if (free) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    last_id_n = gnt_id;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            last_id <= ID_W'(NUM_REQ - 1);
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
            last_id <= last_id_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant-duration counter and forced-release pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            timeout_err <= err_n;
        end
    end
`endif

endmodule
